// File: rtl/difftest_arch_event_collector.sv
// Qualifies commit-stage trap events, buffers them across sink stalls and emits one pulse per event.
// Optional macro ARCH_EVENT_PERF_EN adds perf_events / perf_drops counters.
module difftest_arch_event_collector #(
  parameter int          DEPTH   = 4,
  parameter logic [7:0]  CORE_ID = 8'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_interrupt,
  input  logic [31:0] in_exception,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  input  logic        sink_stall,
  output logic        out_enable,
  output logic        out_valid,
  output logic [31:0] out_interrupt,
  output logic [31:0] out_exception,
  output logic [63:0] out_exceptionPC,
  output logic [31:0] out_exceptionInst,
  output logic [7:0]  out_coreid,
  output logic        overflow
`ifdef ARCH_EVENT_PERF_EN
  ,
  output logic [31:0] perf_events,
  output logic [31:0] perf_drops
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   mem_int_r  [DEPTH];
  logic [31:0]   mem_exc_r  [DEPTH];
  logic [63:0]   mem_pc_r   [DEPTH];
  logic [31:0]   mem_inst_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          out_enable_r;
  logic [31:0]   out_int_r;
  logic [31:0]   out_exc_r;
  logic [63:0]   out_pc_r;
  logic [31:0]   out_inst_r;
  logic          overflow_r;

  logic          push_s;
  logic          pop_s;
  logic          head_avail_s;
  logic          full_s;
  logic          wr_s;
  logic          rd_s;
  logic          drop_s;
  logic [31:0]   in_exc_s;

  assign head_avail_s = (count_r != {CW{1'b0}});
  assign full_s       = (count_r == FULL_COUNT);
  assign push_s       = in_valid && ((in_interrupt != 32'd0) || (in_exception != 32'd0)) && !flush;
  assign pop_s        = !sink_stall && !flush && (head_avail_s || push_s);
  // An incoming event is enqueued unless it bypasses straight to the output; a full queue drops it only when nothing leaves.
  assign wr_s         = push_s && (head_avail_s || sink_stall) && (!full_s || pop_s);
  assign drop_s       = push_s && full_s && !pop_s;
  assign rd_s         = pop_s && head_avail_s;
  assign in_exc_s     = (in_interrupt != 32'd0) ? 32'd0 : in_exception;

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_int_r[i]  <= 32'd0;
        mem_exc_r[i]  <= 32'd0;
        mem_pc_r[i]   <= 64'd0;
        mem_inst_r[i] <= 32'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_s) begin
        mem_int_r[wr_ptr_r]  <= in_interrupt;
        mem_exc_r[wr_ptr_r]  <= in_exc_s;
        mem_pc_r[wr_ptr_r]   <= in_pc;
        mem_inst_r[wr_ptr_r] <= in_inst;
        wr_ptr_r             <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{(CW-1){1'b0}}, wr_s} - {{(CW-1){1'b0}}, rd_s};
    end
  end

  // Output register: fields load on pop from the head or the bypassed input, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_enable_r <= 1'b0;
      out_int_r    <= 32'd0;
      out_exc_r    <= 32'd0;
      out_pc_r     <= 64'd0;
      out_inst_r   <= 32'd0;
    end else if (pop_s) begin
      out_enable_r <= 1'b1;
      if (head_avail_s) begin
        out_int_r  <= mem_int_r[rd_ptr_r];
        out_exc_r  <= mem_exc_r[rd_ptr_r];
        out_pc_r   <= mem_pc_r[rd_ptr_r];
        out_inst_r <= mem_inst_r[rd_ptr_r];
      end else begin
        out_int_r  <= in_interrupt;
        out_exc_r  <= in_exc_s;
        out_pc_r   <= in_pc;
        out_inst_r <= in_inst;
      end
    end else begin
      out_enable_r <= 1'b0;
    end
  end

  // Sticky drop flag; survives flush so lost events stay visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef ARCH_EVENT_PERF_EN
  logic [31:0] perf_events_r;
  logic [31:0] perf_drops_r;

  // Free-running event and drop counters, wrapping at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_events_r <= 32'd0;
      perf_drops_r  <= 32'd0;
    end else begin
      perf_events_r <= perf_events_r + {31'd0, pop_s};
      perf_drops_r  <= perf_drops_r + {31'd0, drop_s};
    end
  end

  assign perf_events = perf_events_r;
  assign perf_drops  = perf_drops_r;
`endif

  assign out_enable        = out_enable_r;
  assign out_valid         = out_enable_r;
  assign out_interrupt     = out_int_r;
  assign out_exception     = out_exc_r;
  assign out_exceptionPC   = out_pc_r;
  assign out_exceptionInst = out_inst_r;
  assign out_coreid        = CORE_ID;
  assign overflow          = overflow_r;

endmodule

// File: tb/tb_difftest_arch_event_collector.sv
// Scoreboard bench for difftest_arch_event_collector: expected events queued at stimulus, checked on each pulse.
module tb_difftest_arch_event_collector;

  localparam int         DEPTH   = 4;
  localparam logic [7:0] CORE_ID = 8'h5A;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_interrupt;
  logic [31:0] in_exception;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        sink_stall;
  logic        out_enable;
  logic        out_valid;
  logic [31:0] out_interrupt;
  logic [31:0] out_exception;
  logic [63:0] out_exceptionPC;
  logic [31:0] out_exceptionInst;
  logic [7:0]  out_coreid;
  logic        overflow;
`ifdef ARCH_EVENT_PERF_EN
  logic [31:0] perf_events;
  logic [31:0] perf_drops;
`endif

  typedef struct {
    logic [31:0] irq;
    logic [31:0] exc;
    logic [63:0] pc;
    logic [31:0] inst;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pulse_cnt = 0;

  difftest_arch_event_collector #(.DEPTH(DEPTH), .CORE_ID(CORE_ID)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_interrupt(in_interrupt), .in_exception(in_exception),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .sink_stall(sink_stall),
    .out_enable(out_enable), .out_valid(out_valid),
    .out_interrupt(out_interrupt), .out_exception(out_exception),
    .out_exceptionPC(out_exceptionPC), .out_exceptionInst(out_exceptionInst),
    .out_coreid(out_coreid), .overflow(overflow)
`ifdef ARCH_EVENT_PERF_EN
    , .perf_events(perf_events), .perf_drops(perf_drops)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every pulse must match the oldest outstanding expected event.
  always @(negedge clock) begin
    if (reset_n && out_enable) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse irq=%h exc=%h pc=%h inst=%h", out_interrupt, out_exception,
                 out_exceptionPC, out_exceptionInst);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (out_interrupt !== e.irq || out_exception !== e.exc || out_exceptionPC !== e.pc ||
            out_exceptionInst !== e.inst || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL event_fields got irq=%h exc=%h pc=%h inst=%h valid=%b want irq=%h exc=%h pc=%h inst=%h valid=1",
                   out_interrupt, out_exception, out_exceptionPC, out_exceptionInst, out_valid,
                   e.irq, e.exc, e.pc, e.inst);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] e,
                        input logic [63:0] p, input logic [31:0] w);
    in_valid = v; in_interrupt = i; in_exception = e; in_pc = p; in_inst = w;
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] e,
                          input logic [63:0] p, input logic [31:0] w);
    ev_t x;
    x.irq = i; x.exc = (i != 32'd0) ? 32'd0 : e; x.pc = p; x.inst = w;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; sink_stall = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_enable !== 1'b0 || out_valid !== 1'b0 || out_interrupt !== 32'd0 || out_exception !== 32'd0 ||
        out_exceptionPC !== 64'd0 || out_exceptionInst !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs en=%b val=%b irq=%h exc=%h pc=%h inst=%h ovf=%b want all 0",
               out_enable, out_valid, out_interrupt, out_exception, out_exceptionPC, out_exceptionInst, overflow);
    end
    checks++;
    if (out_coreid !== CORE_ID) begin
      errors++;
      $display("FAIL coreid got %h want %h", out_coreid, CORE_ID);
    end
    reset_n = 1'b1;
    step();
    pulse_cnt = 0;
`ifdef ARCH_EVENT_PERF_EN
    checks++;
    if (perf_events !== 32'd0 || perf_drops !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset got %0d/%0d want 0/0", perf_events, perf_drops);
    end
`endif
  endtask

  task automatic test_single();
    set_in(1'b1, 32'd0, 32'd2, 64'h8000_0010, 32'h0000_0073);
    push_exp(32'd0, 32'd2, 64'h8000_0010, 32'h0000_0073);
    step();
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    checks++;
    if (out_enable !== 1'b1 || out_exception !== 32'd2 || out_interrupt !== 32'd0 ||
        out_exceptionPC !== 64'h8000_0010 || out_exceptionInst !== 32'h0000_0073) begin
      errors++;
      $display("FAIL single_latency en=%b exc=%h irq=%h pc=%h inst=%h want 1/2/0/80000010/73",
               out_enable, out_exception, out_interrupt, out_exceptionPC, out_exceptionInst);
    end
    step();
    checks++;
    if (out_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width en=%b want 0", out_enable);
    end
    checks++;
    if (out_exception !== 32'd2 || out_exceptionPC !== 64'h8000_0010) begin
      errors++;
      $display("FAIL field_hold exc=%h pc=%h want 2/80000010", out_exception, out_exceptionPC);
    end
  endtask

  task automatic test_priority();
    set_in(1'b1, 32'd7, 32'd5, 64'h8000_0100, 32'h1234_5678);
    push_exp(32'd7, 32'd5, 64'h8000_0100, 32'h1234_5678);
    step();
    set_in(1'b1, 32'd0, 32'd0, 64'h8000_0200, 32'h0);
    checks++;
    if (out_enable !== 1'b1 || out_interrupt !== 32'd7 || out_exception !== 32'd0) begin
      errors++;
      $display("FAIL priority en=%b irq=%h exc=%h want 1/7/0", out_enable, out_interrupt, out_exception);
    end
    step();
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    step();
    checks++;
    if (out_enable !== 1'b0) begin
      errors++;
      $display("FAIL zero_cause_ignored en=%b want 0", out_enable);
    end
  endtask

  task automatic test_full_push_pop();
    int p0;
    p0 = pulse_cnt;
    sink_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'd0, 32'(i + 1), 64'h8000_2000 + 64'(i * 4), 32'hA000_0000 + 32'(i));
      push_exp(32'd0, 32'(i + 1), 64'h8000_2000 + 64'(i * 4), 32'hA000_0000 + 32'(i));
      step();
    end
    sink_stall = 1'b0;
    set_in(1'b1, 32'd3, 32'd0, 64'h8000_2100, 32'hA000_0099);
    push_exp(32'd3, 32'd0, 64'h8000_2100, 32'hA000_0099);
    step();
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_enable !== 1'b1) begin
        errors++;
        $display("FAIL full_drain_cycle%0d en=%b want 1", i, out_enable);
      end
      step();
    end
    checks++;
    if (out_enable !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_no_drop en=%b ovf=%b want 0/0", out_enable, overflow);
    end
    checks++;
    if (pulse_cnt - p0 != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_pulse_count got %0d left %0d want 5 left 0", pulse_cnt - p0, exp_q.size());
    end
`ifdef ARCH_EVENT_PERF_EN
    checks++;
    if (perf_events !== 32'(pulse_cnt) || perf_drops !== 32'd0) begin
      errors++;
      $display("FAIL perf_after_full got %0d/%0d want %0d/0", perf_events, perf_drops, pulse_cnt);
    end
`endif
  endtask

  task automatic test_stall_burst();
    int p0;
    p0 = pulse_cnt;
    sink_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'(i + 16), 32'd0, 64'h8000_3000 + 64'(i * 8), 32'hB000_0000 + 32'(i));
      push_exp(32'(i + 16), 32'd0, 64'h8000_3000 + 64'(i * 8), 32'hB000_0000 + 32'(i));
      step();
    end
    set_in(1'b1, 32'd0, 32'd9, 64'h8000_3FFF, 32'hDEAD_BEEF);
    step();
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %b want 1", overflow);
    end
`ifdef ARCH_EVENT_PERF_EN
    checks++;
    if (perf_drops !== 32'd1) begin
      errors++;
      $display("FAIL perf_drops got %0d want 1", perf_drops);
    end
`endif
    checks++;
    if (pulse_cnt != p0 || out_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_pulse got %0d pulses en=%b want 0 pulses en=0", pulse_cnt - p0, out_enable);
    end
    sink_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      checks++;
      if (out_enable !== 1'b1) begin
        errors++;
        $display("FAIL burst_drain_cycle%0d en=%b want 1", i, out_enable);
      end
    end
    step();
    step();
    checks++;
    if (out_enable !== 1'b0 || pulse_cnt - p0 != DEPTH || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_total en=%b pulses=%0d left=%0d want 0/%0d/0", out_enable, pulse_cnt - p0,
               exp_q.size(), DEPTH);
    end
  endtask

  task automatic test_flush();
    int p0;
    sink_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'd0, 32'(i + 4), 64'h8000_4000 + 64'(i * 4), 32'hC000_0000 + 32'(i));
      step();
    end
    flush = 1'b1;
    set_in(1'b1, 32'd0, 32'd11, 64'h8000_4100, 32'hC000_0100);
    step();
    flush = 1'b0;
    sink_stall = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    p0 = pulse_cnt;
    checks++;
    if (dut.count_r !== 3'd0) begin
      errors++;
      $display("FAIL flush_count got %0d want 0", dut.count_r);
    end
    repeat (4) step();
    checks++;
    if (pulse_cnt != p0 || out_enable !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_pulse got %0d pulses want 0", pulse_cnt - p0);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_keeps_overflow got %b want 1", overflow);
    end
    set_in(1'b1, 32'd0, 32'd13, 64'h8000_4200, 32'hC000_0200);
    push_exp(32'd0, 32'd13, 64'h8000_4200, 32'hC000_0200);
    step();
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    checks++;
    if (out_enable !== 1'b1 || out_exception !== 32'd13) begin
      errors++;
      $display("FAIL post_flush_event en=%b exc=%h want 1/d", out_enable, out_exception);
    end
    step();
  endtask

  task automatic test_reset_mid_drain();
    int p0;
    sink_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'd0, 32'(i + 20), 64'h8000_5000 + 64'(i * 4), 32'hE000_0000 + 32'(i));
      push_exp(32'd0, 32'(i + 20), 64'h8000_5000 + 64'(i * 4), 32'hE000_0000 + 32'(i));
      step();
    end
    set_in(1'b0, 32'd0, 32'd0, 64'd0, 32'd0);
    sink_stall = 1'b0;
    step();
    step();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_enable !== 1'b0 || out_valid !== 1'b0 || out_exception !== 32'd0 ||
        out_exceptionPC !== 64'd0 || out_exceptionInst !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async en=%b val=%b exc=%h pc=%h inst=%h ovf=%b want all 0",
               out_enable, out_valid, out_exception, out_exceptionPC, out_exceptionInst, overflow);
    end
    exp_q.delete();
    p0 = pulse_cnt;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (6) step();
    checks++;
    if (pulse_cnt != p0 || out_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_queue_lost got %0d pulses want 0", pulse_cnt - p0);
    end
`ifdef ARCH_EVENT_PERF_EN
    checks++;
    if (perf_events !== 32'd0 || perf_drops !== 32'd0) begin
      errors++;
      $display("FAIL perf_after_reset got %0d/%0d want 0/0", perf_events, perf_drops);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full_push_pop();
    test_stall_burst();
    test_flush();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
